// File: rtl/symdes_pkg.sv
// Shared types and constants for the 8b/10b symbol deserializer:
// alignment state encoding, K28.5 comma patterns and running-disparity encoding.
package symdes_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } symdes_state_t;

  // K28.5 with bit a in bit 0.
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

endpackage

// File: rtl/symdes_rd_check.sv
// Running-disparity tracker: popcounts each emitted symbol, keeps the rd register
// and flags symbols whose ones-count is illegal for the current disparity.
module symdes_rd_check
  import symdes_pkg::*;
#(
  parameter int SYM_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sym_valid_i,
  input  logic             acquire_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             err_o
);

  localparam int CW = $clog2(SYM_W + 1);
  localparam logic [CW-1:0] HALF = CW'(SYM_W / 2);

  logic          rd_q;
  logic          rd_d;
  logic          bad;
  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < SYM_W; i++) ones = ones + CW'(sym_i[i]);
    rd_d = rd_q;
    bad  = 1'b0;
    // rd follows the symbol even when the symbol itself is in error.
    if (ones == HALF + 1'b1) begin
      bad  = (rd_q == RD_POS);
      rd_d = RD_POS;
    end else if (ones == HALF - 1'b1) begin
      bad  = (rd_q == RD_NEG);
      rd_d = RD_NEG;
    end else if (ones != HALF) begin
      bad = 1'b1;
    end
  end

  // The acquiring comma seeds rd but is never reported as an error.
  assign err_o = sym_valid_i & ~acquire_i & bad;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)           rd_q <= RD_NEG;
    else if (sym_valid_i) rd_q <= rd_d;
  end

endmodule

// File: rtl/symbol_deserializer.sv
// Serial-to-parallel 8b/10b receiver with K28.5 comma alignment (HUNT/SYNC/LOCKED).
// Optional running-disparity checking is built when SYMDES_RD_CHECK_EN is defined.
module symbol_deserializer
  import symdes_pkg::*;
#(
  parameter int               SYM_W    = 10,
  parameter logic [SYM_W-1:0] COMMA_P  = SYM_W'(K28_5_RDN),
  parameter logic [SYM_W-1:0] COMMA_N  = SYM_W'(K28_5_RDP),
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             serial_i,
  input  logic             align_en_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  output logic             comma_o,
  output logic             locked_o,
  output logic             lock_lost_o,
  output logic             disp_err_o,
  output symdes_state_t    state_o
);

  localparam int BCW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam int BW  = $clog2(LOSS_CNT + 1);

  symdes_state_t    state_q, state_d;
  logic [SYM_W-2:0] sr_q, sr_d;
  logic [SYM_W-1:0] cand;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [BW-1:0]    bad_q, bad_d, bad_inc;
  logic             match, boundary, emit, lost, rd_err;

  // Output strobe: sym_valid_o is high for exactly one clock, the clock after the
  // enabled cycle that carried a symbol's last bit; comma_o/disp_err_o qualify it.
  assign cand     = {serial_i, sr_q};
  assign match    = (cand == COMMA_P) || (cand == COMMA_N);
  assign boundary = (bit_cnt_q == BCW'(SYM_W - 1));

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    good_d    = good_q;
    bad_d     = bad_q;
    good_inc  = (good_q == GW'(LOCK_CNT)) ? good_q : good_q + 1'b1;
    bad_inc   = (bad_q == BW'(LOSS_CNT)) ? bad_q : bad_q + 1'b1;
    emit      = 1'b0;
    lost      = 1'b0;
    if (en_i) begin
      sr_d      = cand[SYM_W-1:1];
      bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (align_en_i && match) begin
            bit_cnt_d = '0;
            emit      = 1'b1;
            good_d    = GW'(1);
            state_d   = (LOCK_CNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (boundary) begin
            emit = 1'b1;
            if (match) begin
              good_d = good_inc;
              if (good_inc == GW'(LOCK_CNT)) state_d = LOCKED;
            end
          end else if (align_en_i && match) begin
            bit_cnt_d = '0;
            emit      = 1'b1;
            good_d    = GW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            emit = 1'b1;
            if (match) bad_d = '0;
          end else if (align_en_i && match) begin
            // Misaligned commas only count towards loss; lock never realigns in place.
            if (bad_inc == BW'(LOSS_CNT)) begin
              state_d = HUNT;
              lost    = 1'b1;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef SYMDES_RD_CHECK_EN
  symdes_rd_check #(.SYM_W(SYM_W)) u_rd_check (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sym_valid_i (emit),
    .acquire_i   (state_q == HUNT),
    .sym_i       (cand),
    .err_o       (rd_err)
  );
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sym_o       <= '0;
      sym_valid_o <= 1'b0;
      comma_o     <= 1'b0;
      lock_lost_o <= 1'b0;
      disp_err_o  <= 1'b0;
    end else begin
      sym_valid_o <= emit;
      comma_o     <= emit & match;
      lock_lost_o <= lost;
      disp_err_o  <= emit & rd_err;
      if (emit) sym_o <= cand;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign state_o  = state_q;

endmodule

// File: tb/tb_symbol_deserializer.sv
// Self-checking bench for symbol_deserializer: randomized and directed serial streams
// scored against a bit-history reference model of the alignment rules.
`timescale 1ns/1ps
module tb_symbol_deserializer;
  import symdes_pkg::*;

  localparam int SYM_W    = 10;
  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  localparam int REC_W    = 28;  // {cycle[15:0], disp_err, comma, sym[9:0]}
  localparam logic [9:0] KP = 10'h17C;
  localparam logic [9:0] KN = 10'h283;

  // ---------------- clock / reset / DUT ----------------
  logic clk_i = 1'b0, rst_i = 1'b0, en_i = 1'b0, serial_i = 1'b0, align_en_i = 1'b0;
  logic [SYM_W-1:0] sym_o;
  logic sym_valid_o, comma_o, locked_o, lock_lost_o, disp_err_o;
  symdes_state_t state_o;

  symbol_deserializer #(
    .SYM_W(SYM_W), .COMMA_P(KP), .COMMA_N(KN), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .serial_i(serial_i), .align_en_i(align_en_i),
    .sym_o(sym_o), .sym_valid_o(sym_valid_o), .comma_o(comma_o), .locked_o(locked_o),
    .lock_lost_o(lock_lost_o), .disp_err_o(disp_err_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard queues ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];
  int exp_lost_q[$], got_lost_q[$], exp_rise_q[$], got_rise_q[$];
  logic prev_locked = 1'b0;
  int n_vec = 0, n_err = 0;

  always @(negedge clk_i) begin
    if (sym_valid_o === 1'b1) got_q.push_back({cyc[15:0], disp_err_o, comma_o, sym_o});
    if (lock_lost_o === 1'b1) got_lost_q.push_back(cyc);
    if (locked_o === 1'b1 && prev_locked !== 1'b1) got_rise_q.push_back(cyc);
    prev_locked = locked_o;
  end

  // ---------------- reference model ----------------
  // Alignment is an absolute bit index (anchor); boundaries are every SYM_W bits after it.
  logic m_hist[$];
  int   m_nbits, m_anchor, m_phase, m_good, m_bad;
  logic m_rd;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYM_W; i++) m_hist.push_back(1'b0);
    m_nbits = 0; m_anchor = -1; m_phase = 0; m_good = 0; m_bad = 0; m_rd = 1'b0;
    exp_q.delete(); got_q.delete();
    exp_lost_q.delete(); got_lost_q.delete(); exp_rise_q.delete(); got_rise_q.delete();
  endtask

  task automatic model_bit(input logic b, input logic al);
    logic [9:0] cand;
    logic [15:0] tag;
    logic is_k, bound, emit, acq, derr;
    int k, ones;
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    for (int i = 0; i < SYM_W; i++) cand[i] = m_hist[i];
    tag   = 16'(cyc + 1);
    k     = m_nbits;
    m_nbits++;
    is_k  = (cand == KP) || (cand == KN);
    bound = ((k - m_anchor) % SYM_W) == 0;
    emit  = 1'b0; acq = 1'b0; derr = 1'b0;
    if (m_phase == 0) begin
      if (al && is_k) begin
        m_anchor = k; emit = 1'b1; acq = 1'b1; m_good = 1;
        m_phase = (LOCK_CNT == 1) ? 2 : 1;
        if (m_phase == 2) exp_rise_q.push_back(cyc + 1);
      end
    end else if (m_phase == 1) begin
      if (bound) begin
        emit = 1'b1;
        if (is_k) begin
          if (m_good < LOCK_CNT) m_good++;
          if (m_good >= LOCK_CNT) begin m_phase = 2; exp_rise_q.push_back(cyc + 1); end
        end
      end else if (al && is_k) begin
        m_anchor = k; emit = 1'b1; m_good = 1;
      end
    end else begin
      if (bound) begin
        emit = 1'b1;
        if (is_k) m_bad = 0;
      end else if (al && is_k) begin
        m_bad++;
        if (m_bad >= LOSS_CNT) begin
          m_phase = 0; m_good = 0; m_bad = 0; exp_lost_q.push_back(cyc + 1);
        end
      end
    end
    if (emit) begin
`ifdef SYMDES_RD_CHECK_EN
      ones = $countones(cand);
      if (ones == 6)      begin derr = !acq && m_rd;  m_rd = 1'b1; end
      else if (ones == 4) begin derr = !acq && !m_rd; m_rd = 1'b0; end
      else if (ones != 5) derr = !acq;
`else
      ones = 0;
`endif
      exp_q.push_back({tag, derr, is_k, cand});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic b, input logic al);
    en_i = en; serial_i = b; align_en_i = al;
    if (en) model_bit(b, al);
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_bits(input logic [9:0] w, input int n, input int gap, input logic al);
    for (int i = 0; i < n; i++) begin
      repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), al);
      step(1'b1, w[i], al);
    end
  endtask

  task automatic do_reset();
    en_i = 1'b0;
    #2 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b0; en_i = 1'b1; serial_i = 1'b1; align_en_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    n_vec++;
    if ({sym_valid_o, comma_o, locked_o, lock_lost_o, disp_err_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: observed %b, expected 00000",
               {sym_valid_o, comma_o, locked_o, lock_lost_o, disp_err_o});
    end
    n_vec++;
    if (sym_o !== '0) begin n_err++; $display("FAIL reset_sym: observed %h, expected 000", sym_o); end
    n_vec++;
    if (state_o !== HUNT) begin n_err++; $display("FAIL reset_state: observed %0d, expected %0d", state_o, HUNT); end
    en_i = 1'b0;
    rst_i = 1'b1;
    model_reset();
    repeat (50) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    settle();
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL reset_no_sym: observed %0d symbols, expected 0", got_q.size()); end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL reset_model: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_acquire();
    do_reset();
    send_bits(10'b101, 3, 0, 1'b1);
    send_bits(KP, 10, 0, 1'b1);
    n_vec++;
    if (!(sym_valid_o === 1'b1 && comma_o === 1'b1 && sym_o === KP)) begin
      n_err++; $display("FAIL acq_comma: observed v=%b c=%b sym=%h, expected v=1 c=1 sym=17c", sym_valid_o, comma_o, sym_o);
    end
    send_bits(10'h274, 10, 0, 1'b1);
    n_vec++;
    if (!(sym_valid_o === 1'b1 && comma_o === 1'b0 && sym_o === 10'h274)) begin
      n_err++; $display("FAIL acq_data: observed v=%b c=%b sym=%h, expected v=1 c=0 sym=274", sym_valid_o, comma_o, sym_o);
    end
    settle();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL acq_count: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL acq_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    send_bits(KP, 10, 0, 1'b1); send_bits(10'h074, 10, 0, 1'b1);
    send_bits(KN, 10, 0, 1'b1); send_bits(10'h15B, 10, 0, 1'b1);
    n_vec++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL lock_early: observed %b, expected 0", locked_o); end
    send_bits(KP, 10, 0, 1'b1);
    n_vec++;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL lock_rise: observed %b, expected 1", locked_o); end
    settle();
    n_vec++;
    if (got_rise_q.size() != 1 || exp_rise_q.size() != 1 || got_rise_q[0] != exp_rise_q[0]) begin
      n_err++; $display("FAIL lock_cycle: observed %p, expected %p", got_rise_q, exp_rise_q);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL lock_count: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL lock_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete(); got_rise_q.delete(); exp_rise_q.delete();
  endtask

  task automatic test_loss();
    send_bits(10'h074 >> 1, 9, 0, 1'b1);
    send_bits(KP, 10, 0, 1'b1);
    send_bits(KN, 10, 0, 1'b1);
    settle();
    n_vec++;
    if (got_lost_q.size() != 1 || exp_lost_q.size() != 1 || got_lost_q[0] != exp_lost_q[0]) begin
      n_err++; $display("FAIL loss_pulse: observed %p, expected %p", got_lost_q, exp_lost_q);
    end
    n_vec++;
    if (locked_o !== 1'b0) begin n_err++; $display("FAIL loss_locked: observed %b, expected 0", locked_o); end
    send_bits(KP, 10, 0, 1'b1);
    send_bits(10'h274, 10, 0, 1'b1);
    settle();
    n_vec++;
    if (got_q.size() < 2 || got_q[got_q.size()-2][9:0] !== KP || got_q[got_q.size()-2][10] !== 1'b1) begin
      n_err++; $display("FAIL loss_reacq: observed %0d records, expected reacquired 17c comma", got_q.size());
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL loss_count: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL loss_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_en_gaps();
    logic [9:0] words [5];
    words = '{KP, 10'h074, KN, 10'h15B, KP};
    do_reset();
    foreach (words[i]) send_bits(words[i], 10, 2, 1'b1);
    settle();
    n_vec++;
    if (locked_o !== 1'b1) begin n_err++; $display("FAIL gap_locked: observed %b, expected 1", locked_o); end
    n_vec++;
    if (got_q.size() != 5) begin n_err++; $display("FAIL gap_count: observed %0d, expected 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_vec++;
      if (got_q[i][9:0] !== words[i]) begin n_err++; $display("FAIL gap_sym[%0d]: observed %h, expected %h", i, got_q[i][9:0], words[i]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gap_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rd();
    logic [3:0] exp_d;
    logic [9:0] words [4];
    words = '{KP, 10'h15B, 10'h074, 10'h274};
`ifdef SYMDES_RD_CHECK_EN
    exp_d = 4'b0010;
`else
    exp_d = 4'b0000;
`endif
    do_reset();
    foreach (words[i]) send_bits(words[i], 10, 0, 1'b1);
    settle();
    n_vec++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL rd_count: observed %0d, expected 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_vec++;
      if (got_q[i][11] !== exp_d[i]) begin n_err++; $display("FAIL rd_err[%0d]: observed %b, expected %b", i, got_q[i][11], exp_d[i]); end
      n_vec++;
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rd_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bits(KP, 10, 0, 1'b1);
    send_bits(10'h274, 10, 0, 1'b1);
    send_bits(10'h074, 5, 0, 1'b1);
    #3 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_vec++;
    if (sym_valid_o !== 1'b0 || locked_o !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: observed v=%b l=%b, expected 0 0", sym_valid_o, locked_o);
    end
    rst_i = 1'b1;
    model_reset();
    send_bits(10'h074 >> 5, 5, 0, 1'b1);
    settle();
    n_vec++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL mid_partial: observed %0d symbols, expected 0 (model %0d)", got_q.size(), exp_q.size());
    end
    send_bits(KP, 10, 0, 1'b1);
    settle();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_count: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [9:0] w;
    int n;
    logic al;
    do_reset();
    for (int wi = 0; wi < 70; wi++) begin
      case ($urandom_range(0, 9))
        0, 1:    w = KP;
        2, 3:    w = KN;
        default: w = 10'($urandom_range(0, 1023));
      endcase
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 9) : 10;
      for (int i = 0; i < n; i++) begin
        al = ($urandom_range(0, 9) != 0);
        while ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), al);
        step(1'b1, w[i], al);
      end
    end
    settle();
    n_vec++;
    if (locked_o !== (m_phase == 2)) begin n_err++; $display("FAIL rnd_locked: observed %b, expected %b", locked_o, m_phase == 2); end
    n_vec++;
    if (got_lost_q.size() != exp_lost_q.size()) begin n_err++; $display("FAIL rnd_lost: observed %p, expected %p", got_lost_q, exp_lost_q); end
    for (int i = 0; i < got_lost_q.size() && i < exp_lost_q.size(); i++) begin
      n_vec++;
      if (got_lost_q[i] != exp_lost_q[i]) begin n_err++; $display("FAIL rnd_lost[%0d]: observed %0d, expected %0d", i, got_lost_q[i], exp_lost_q[i]); end
    end
    n_vec++;
    if (got_rise_q.size() != exp_rise_q.size()) begin n_err++; $display("FAIL rnd_rise: observed %p, expected %p", got_rise_q, exp_rise_q); end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count: observed %0d, expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_rec[%0d]: observed %h, expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_lock();
    test_loss();
    test_en_gaps();
    test_rd();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
